// File: rtl/lc_cfg_loader.sv
// Logic-cell configuration loader: gathers 3-byte frames from a byte stream and
// shifts each 21-bit cbit frame MSB-first into the serial cell chain, then latches.
module lc_cfg_loader #(
  parameter int NUM_CELLS = 8,
  parameter int CBIT_W    = 21
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  output logic       in_ready_o,
  output logic       prog_o,
  output logic       cfg_shift_o,
  output logic       cfg_sdo_o,
  output logic       cfg_latch_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_SHIFT, S_LATCH, S_DONE} state_e;

  localparam logic [7:0] LAST_CELL = 8'(NUM_CELLS - 1);
  localparam logic [4:0] LAST_BIT  = 5'(CBIT_W - 1);

  state_e              state_q;
  logic [1:0]          byte_q;
  logic [15:0]         lut_q;
  logic [CBIT_W-1:0]   sr_q;
  logic [4:0]          bit_q;
  logic [7:0]          cell_q, cell_d;
  logic                in_ready_q, prog_q, shift_q, sdo_q, latch_q, busy_q, done_q, err_q;

  assign cell_d = cell_q + 8'd1;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      byte_q     <= '0;
      lut_q      <= '0;
      sr_q       <= '0;
      bit_q      <= '0;
      cell_q     <= '0;
      in_ready_q <= 1'b0;
      prog_q     <= 1'b0;
      shift_q    <= 1'b0;
      sdo_q      <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (abort_i) begin
      // err is deliberately kept so software can still see a prior format error
      state_q    <= S_IDLE;
      byte_q     <= '0;
      bit_q      <= '0;
      cell_q     <= '0;
      in_ready_q <= 1'b0;
      prog_q     <= 1'b0;
      shift_q    <= 1'b0;
      sdo_q      <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      latch_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q    <= S_COLLECT;
            err_q      <= 1'b0;
            cell_q     <= '0;
            byte_q     <= '0;
            in_ready_q <= 1'b1;
            prog_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (in_valid_i && in_ready_q) begin
            case (byte_q)
              2'd0: begin
                lut_q[7:0] <= in_data_i;
                byte_q     <= 2'd1;
              end
              2'd1: begin
                lut_q[15:8] <= in_data_i;
                byte_q      <= 2'd2;
              end
              default: begin
                byte_q     <= '0;
                in_ready_q <= 1'b0;
                if (in_data_i[7:5] != 3'd0) begin
                  state_q <= S_IDLE;
                  err_q   <= 1'b1;
                  prog_q  <= 1'b0;
                  busy_q  <= 1'b0;
                end else begin
                  // C_ON goes out immediately; the rest waits MSB-aligned in sr_q
                  state_q <= S_SHIFT;
                  shift_q <= 1'b1;
                  sdo_q   <= in_data_i[4];
                  sr_q    <= {in_data_i[3:0], lut_q, 1'b0};
                  bit_q   <= '0;
                end
              end
            endcase
          end
        end
        S_SHIFT: begin
          if (bit_q == LAST_BIT) begin
            shift_q <= 1'b0;
            sdo_q   <= 1'b0;
            cell_q  <= cell_d;
            if (cell_q == LAST_CELL) begin
              state_q <= S_LATCH;
              latch_q <= 1'b1;
            end else begin
              state_q    <= S_COLLECT;
              in_ready_q <= 1'b1;
            end
          end else begin
            bit_q <= bit_q + 5'd1;
            sdo_q <= sr_q[CBIT_W-1];
            sr_q  <= {sr_q[CBIT_W-2:0], 1'b0};
          end
        end
        S_LATCH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          prog_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign prog_o      = prog_q;
  assign cfg_shift_o = shift_q;
  assign cfg_sdo_o   = sdo_q;
  assign cfg_latch_o = latch_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_lc_cfg_loader.sv
// Scoreboard bench for lc_cfg_loader: frames are turned into expected chain events
// (bits, latch, done) at issue time; negedge monitors pop and compare per DUT.
module tb_lc_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, start1, start8, abort, in_valid;
  logic [7:0] in_data;
  logic ready1, prog1, shift1, sdo1, latch1, busy1, done1, err1;
  logic ready8, prog8, shift8, sdo8, latch8, busy8, done8, err8;

  lc_cfg_loader #(.NUM_CELLS(1), .CBIT_W(21)) dut1 (
    .clk_i(clk), .resetn_i(resetn), .start_i(start1), .abort_i(abort),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(ready1), .prog_o(prog1),
    .cfg_shift_o(shift1), .cfg_sdo_o(sdo1), .cfg_latch_o(latch1), .busy_o(busy1),
    .done_o(done1), .err_o(err1));

  lc_cfg_loader #(.NUM_CELLS(8), .CBIT_W(21)) dut8 (
    .clk_i(clk), .resetn_i(resetn), .start_i(start8), .abort_i(abort),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(ready8), .prog_o(prog8),
    .cfg_shift_o(shift8), .cfg_sdo_o(sdo8), .cfg_latch_o(latch8), .busy_o(busy8),
    .done_o(done8), .err_o(err8));

  // code: 0/1 = shifted bit value, 2 = latch, 3 = done; consec = must follow previous event by one cycle
  typedef struct packed {logic [1:0] code; logic consec;} ev_t;

  ev_t q1[$], q8[$];
  int  n_cmp = 0, n_fail = 0, cyc = 0;
  int  sh1 = 0, lat1 = 0, don1 = 0, last1 = 0, mc1 = 0;
  int  sh8 = 0, lat8 = 0, don8 = 0, last8 = 0, mc8 = 0;
  ev_t e1, e8;
  bit  h1, h8;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void cmp_ev(input string nm, input bit have, input ev_t e,
                                 input logic [1:0] code, input int gap, input logic prog);
    n_cmp++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected event code %0d at cycle %0d", nm, code, cyc);
    end else if (e.code !== code || (e.consec && gap != 1) || prog !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got code %0d gap %0d prog %0b, want code %0d consec %0b",
               nm, code, gap, prog, e.code, e.consec);
    end
  endfunction

  always @(negedge clk) if (resetn) begin
    if (shift1) begin
      h1 = q1.size() > 0; e1 = '0; if (h1) e1 = q1.pop_front();
      cmp_ev("dut1 bit", h1, e1, {1'b0, sdo1}, cyc - last1, prog1); last1 = cyc; sh1++;
    end else check("dut1 sdo idle", {31'd0, sdo1}, 32'd0);
    if (latch1) begin
      h1 = q1.size() > 0; e1 = '0; if (h1) e1 = q1.pop_front();
      cmp_ev("dut1 latch", h1, e1, 2'd2, cyc - last1, prog1); last1 = cyc; lat1++;
    end
    if (done1) begin
      h1 = q1.size() > 0; e1 = '0; if (h1) e1 = q1.pop_front();
      cmp_ev("dut1 done", h1, e1, 2'd3, cyc - last1, prog1); last1 = cyc; don1++;
    end
  end

  always @(negedge clk) if (resetn) begin
    if (shift8) begin
      h8 = q8.size() > 0; e8 = '0; if (h8) e8 = q8.pop_front();
      cmp_ev("dut8 bit", h8, e8, {1'b0, sdo8}, cyc - last8, prog8); last8 = cyc; sh8++;
    end else check("dut8 sdo idle", {31'd0, sdo8}, 32'd0);
    if (latch8) begin
      h8 = q8.size() > 0; e8 = '0; if (h8) e8 = q8.pop_front();
      cmp_ev("dut8 latch", h8, e8, 2'd2, cyc - last8, prog8); last8 = cyc; lat8++;
    end
    if (done8) begin
      h8 = q8.size() > 0; e8 = '0; if (h8) e8 = q8.pop_front();
      cmp_ev("dut8 done", h8, e8, 2'd3, cyc - last8, prog8); last8 = cyc; don8++;
    end
  end

  // Reference model: a legal frame becomes 21 chain bits, MSB first; the last cell adds latch+done
  function automatic void push_frame(input int d, input logic [15:0] lut, input logic [4:0] hdr);
    logic [20:0] f;
    ev_t e;
    f = {hdr, lut};
    for (int i = 20; i >= 0; i--) begin
      e.code = {1'b0, f[i]}; e.consec = (i != 20);
      if (d == 1) q1.push_back(e); else q8.push_back(e);
    end
    if (d == 1) mc1++; else mc8++;
    if ((d == 1 && mc1 == 1) || (d == 8 && mc8 == 8)) begin
      e.code = 2'd2; e.consec = 1'b1;
      if (d == 1) q1.push_back(e); else q8.push_back(e);
      e.code = 2'd3;
      if (d == 1) q1.push_back(e); else q8.push_back(e);
      if (d == 1) mc1 = 0; else mc8 = 0;
    end
  endfunction

  // Called just after a negedge; returns just after the negedge following consumption
  task automatic send_byte(input int d, input logic [7:0] b, input int gmax);
    int t;
    repeat ($urandom_range(gmax, 0)) @(negedge clk);
    in_valid = 1'b1; in_data = b; t = 0;
    while (((d == 1) ? ready1 : ready8) !== 1'b1 && t < 500) begin
      @(negedge clk); t++;
    end
    if (t >= 500) begin
      n_cmp++; n_fail++;
      $display("FAIL in_ready wait: dut%0d never ready after %0d cycles, want ready", d, t);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic send_frame(input int d, input logic [15:0] lut, input logic [7:0] b2, input int gmax);
    if (b2[7:5] == 3'd0) push_frame(d, lut, b2[4:0]);
    send_byte(d, lut[7:0], gmax);
    send_byte(d, lut[15:8], gmax);
    send_byte(d, b2, gmax);
  endtask

  task automatic start_session(input int d);
    if (d == 1) start1 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    if (d == 1) mc1 = 0; else mc8 = 0;
    check("start busy", {31'd0, (d == 1) ? busy1 : busy8}, 32'd1);
    check("start err clear", {31'd0, (d == 1) ? err1 : err8}, 32'd0);
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while (((d == 1) ? busy1 : busy8) === 1'b1 && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) begin
      n_cmp++; n_fail++;
      $display("FAIL idle wait: dut%0d still busy after %0d cycles, want idle", d, t);
    end
    repeat (2) @(negedge clk);
    check("queue drained", (d == 1) ? q1.size() : q8.size(), 32'd0);
  endtask

  task automatic full_session8(input int gmax);
    int s0, l0, d0;
    s0 = sh8; l0 = lat8; d0 = don8;
    start_session(8);
    for (int c = 0; c < 8; c++)
      send_frame(8, 16'($urandom), {3'd0, 5'($urandom)}, gmax);
    wait_idle(8);
    check("session shift count", sh8 - s0, 32'd168);
    check("session latch count", lat8 - l0, 32'd1);
    check("session done count", don8 - d0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, d0;
    resetn = 1'b0; start1 = 1'b0; start8 = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check("reset outs dut1", {24'd0, ready1, prog1, shift1, sdo1, latch1, busy1, done1, err1}, 32'd0);
    check("reset outs dut8", {24'd0, ready8, prog8, shift8, sdo8, latch8, busy8, done8, err8}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // single-cell known frame
    start_session(1);
    send_frame(1, 16'hABCD, 8'h15, 0);
    wait_idle(1);
    check("dut1 shift count", sh1, 32'd21);
    check("dut1 latch count", lat1, 32'd1);
    check("dut1 done count", don1, 32'd1);

    // eight random frames with gaps, plus a start pulse mid-SHIFT
    s0 = sh8; l0 = lat8; d0 = don8;
    start_session(8);
    for (int c = 0; c < 8; c++) begin
      send_frame(8, 16'($urandom), {3'd0, 5'($urandom)}, 4);
      if (c == 2) begin
        check("in shift for start poke", {31'd0, shift8}, 32'd1);
        start8 = 1'b1; @(negedge clk); start8 = 1'b0;
      end
    end
    wait_idle(8);
    check("gap session shift count", sh8 - s0, 32'd168);
    check("gap session latch count", lat8 - l0, 32'd1);
    check("gap session done count", don8 - d0, 32'd1);

    // format error in cell 3
    l0 = lat8; d0 = don8;
    start_session(8);
    for (int c = 0; c < 3; c++) send_frame(8, 16'($urandom), {3'd0, 5'($urandom)}, 2);
    send_frame(8, 16'($urandom), 8'h20, 2);
    check("err set", {31'd0, err8}, 32'd1);
    check("err prog drop", {31'd0, prog8}, 32'd0);
    check("err busy drop", {31'd0, busy8}, 32'd0);
    repeat (20) @(negedge clk);
    check("err sticky", {31'd0, err8}, 32'd1);
    check("err no latch", lat8 - l0, 32'd0);
    check("err no done", don8 - d0, 32'd0);
    check("err queue empty", q8.size(), 32'd0);

    // restart clears err; abort at shift bit 10
    start_session(8);
    send_frame(8, 16'($urandom), {3'd0, 5'($urandom)}, 0);
    repeat (10) @(negedge clk);
    check("abort at shift", {31'd0, shift8}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    q8.delete();
    check("abort outs", {24'd0, ready8, prog8, shift8, sdo8, latch8, busy8, done8, err8}, 32'd0);
    @(negedge clk);
    full_session8(3);

    // start and abort together in IDLE
    start8 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start8 = 1'b0; abort = 1'b0;
    check("start+abort busy", {31'd0, busy8}, 32'd0);
    check("start+abort prog", {31'd0, prog8}, 32'd0);

    // reset after byte1 of a frame; stale bytes must not leak into the next session
    start_session(8);
    send_byte(8, 8'($urandom), 0);
    send_byte(8, 8'($urandom), 0);
    resetn = 1'b0;
    @(negedge clk);
    check("reset mid outs", {24'd0, ready8, prog8, shift8, sdo8, latch8, busy8, done8, err8}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    full_session8(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lc_cfg_loader.md
LC_CFG_LOADER -- requirements
Module: lc_cfg_loader

Interface
REQ-001 Parameter NUM_CELLS, default 8, SHALL set the number of logic-cell frames per load session (legal range 1..255).
REQ-002 Parameter CBIT_W, default 21, SHALL set the frame width {C_ON, SEQ_MODE[3:0], LUT_INIT[15:0]}; only 21 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 resetn  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  input  1  SHALL request a load session; sampled only in IDLE.
REQ-006 abort  input  1  SHALL cancel the session from any state.
REQ-007 in_valid  input  1  SHALL qualify in_data.
REQ-008 in_data  input  8  SHALL be the configuration byte stream.
REQ-009 in_ready  output  1  SHALL signal that a byte is accepted this cycle.
REQ-010 prog  output  1  SHALL be high while the target chain is being programmed.
REQ-011 cfg_shift  output  1  SHALL be the shift enable for the serial cell chain.
REQ-012 cfg_sdo  output  1  SHALL be the serial cbit data, valid when cfg_shift=1.
REQ-013 cfg_latch  output  1  SHALL be a one-cycle strobe that commits the shifted chain.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 done  output  1  SHALL be a one-cycle pulse on successful completion.
REQ-016 err  output  1  SHALL be a sticky format-error flag.

Function
REQ-017 States SHALL be IDLE, COLLECT, SHIFT, LATCH, DONE.
REQ-018 IDLE->COLLECT on start=1 and abort=0; err SHALL clear on that edge; the cell counter SHALL clear.
REQ-019 in_ready SHALL be 1 only in COLLECT; a byte is consumed on in_valid & in_ready.
REQ-020 Frame byte order: byte0=LUT_INIT[7:0], byte1=LUT_INIT[15:8], byte2[4:0]={C_ON,SEQ_MODE[3:0]}.
REQ-021 byte2[7:5]!=0 SHALL set err, drop prog, and go to IDLE next cycle, with no latch and no done.
REQ-022 After a legal byte2, the FSM SHALL enter SHIFT on the next cycle.
REQ-023 SHIFT SHALL assert cfg_shift for exactly 21 consecutive cycles, sending MSB first (bit 20 = C_ON first, LUT_INIT[0] last).
REQ-024 After the 21st shift bit, the cell counter SHALL increment; below NUM_CELLS the FSM returns to COLLECT, at NUM_CELLS it goes to LATCH.
REQ-025 LATCH SHALL assert cfg_latch for one cycle and then go to DONE.
REQ-026 DONE SHALL assert done for one cycle, deassert prog on exit, and return to IDLE.
REQ-027 prog SHALL be 1 from the cycle after start acceptance through the DONE cycle inclusive.
REQ-028 abort=1 in any state SHALL go to IDLE next cycle: prog, cfg_shift, cfg_latch=0, no done, err unchanged, and partial frame bytes discarded.
REQ-029 If start and abort are both 1 in IDLE, abort SHALL win and the FSM stays in IDLE.
REQ-030 start asserted outside IDLE SHALL be ignored.
REQ-031 in_valid idle gaps in COLLECT SHALL stall the FSM indefinitely with no timeout.
REQ-032 cfg_sdo SHALL be 0 whenever cfg_shift=0.

Reset
REQ-033 When resetn=0 at a clk edge: state=IDLE; in_ready, prog, cfg_shift, cfg_sdo, cfg_latch, busy, done, err all 0; counters 0.
REQ-034 Reset mid-session SHALL behave as abort and also clear err.

Verification
REQ-035 NUM_CELLS=1; start, then bytes 0xCD,0xAB,0x15 -> cfg_shift for 21 cycles with sdo stream 1,0101,1010101111001101; cfg_latch 1 cycle later; done 1 cycle after that; prog high throughout.
REQ-036 NUM_CELLS=8 with random in_valid gaps -> exactly 168 cfg_shift cycles, one cfg_latch, one done, and the bit stream matches the frames in input order.
REQ-037 byte2=0x20 in cell 3 -> err=1, prog=0 next cycle, no cfg_latch, no done; err stays 1 until the next accepted start, where it clears.
REQ-038 abort during SHIFT bit 10 -> IDLE next cycle, cfg_shift=0, no latch or done; a following start reloads cleanly from cell 0.
REQ-039 start and abort together in IDLE -> busy stays 0; start during SHIFT -> no effect on the bit count.
REQ-040 resetn=0 during COLLECT after byte1 -> all outputs 0 next cycle; a new session ignores the stale bytes.
